// File: rtl/serdes_pkg.sv
// Shared types and widths for the word-to-byte serializer and its FIFO.
package serdes_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        SHIFT = 1'b1
    } shift_state_e;

    typedef struct packed {
        logic              last;
        logic [WORD_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with synchronous reset and full/empty/count status.
// A freshly written entry becomes readable one cycle after its write edge.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             wrote_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wrote_q  <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            wrote_q <= do_push;
        end
    end

    // Storage carries no reset so it can map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem[rd_ptr_q];
    assign full    = (count_q == CW'(DEPTH));
    // The newest entry is hidden for the cycle after it is written.
    assign empty   = ((count_q - CW'(wrote_q)) == '0);
    assign count   = count_q;

endmodule

// File: rtl/word_byte_serializer.sv
// Buffers 32-bit words in a small FIFO and emits them as a gap-free byte stream
// with valid/ready handshakes on both sides and a running accepted-byte counter.
module word_byte_serializer
    import serdes_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [7:0]       out_byte,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic [CNT_W-1:0] byte_count,
    output logic             busy
);

    localparam int                IDX_W    = $clog2(BYTES_PER_WORD);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(BYTES_PER_WORD - 1);

    fifo_entry_t             wr_entry;
    fifo_entry_t             rd_entry;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic                    fifo_pop;
    logic                    fifo_push;

    shift_state_e            state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [WORD_W-1:0]       word_q, word_d;
    logic                    last_q, last_d;
    logic [CNT_W-1:0]        byte_count_q;
    logic [IDX_W-1:0]        sel;
    logic                    beat;

    assign in_ready  = !fifo_full && !rst;
    assign fifo_push = in_valid && in_ready;
    assign wr_entry  = '{last: in_last, data: in_data};

    sync_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .wr_data (wr_entry),
        .pop     (fifo_pop),
        .rd_data (rd_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign out_valid = (state_q == SHIFT);
    assign beat      = out_valid && out_ready;
    assign sel       = MSB_FIRST ? (IDX_LAST - idx_q) : idx_q;
    assign out_byte  = out_valid ? word_q[sel*BYTE_W +: BYTE_W] : '0;
    assign out_last  = out_valid && (idx_q == IDX_LAST) && last_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        word_d   = word_q;
        last_d   = last_q;
        fifo_pop = 1'b0;
        case (state_q)
            EMPTY: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    word_d   = rd_entry.data;
                    last_d   = rd_entry.last;
                    idx_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (beat) begin
                    if (idx_q != IDX_LAST) begin
                        idx_d = idx_q + 1'b1;
                    end else if (!fifo_empty) begin
                        // Back-to-back reload keeps the byte stream free of bubbles.
                        fifo_pop = 1'b1;
                        word_d   = rd_entry.data;
                        last_d   = rd_entry.last;
                        idx_d    = '0;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EMPTY;
            idx_q        <= '0;
            word_q       <= '0;
            last_q       <= 1'b0;
            byte_count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            last_q  <= last_d;
            if (beat) byte_count_q <= byte_count_q + 1'b1;
        end
    end

    assign byte_count = byte_count_q;
    assign busy       = (fifo_count != '0) || (state_q == SHIFT);

endmodule

// File: tb/tb_word_byte_serializer.sv
// Directed bench for word_byte_serializer: three instances (default, LSB-first,
// 4-bit counter) driven in lockstep; one is observed per test through a mux.
module tb_word_byte_serializer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_last, out_ready;
    logic [31:0] in_data;

    logic        a_in_ready, a_out_valid, a_out_last, a_busy;
    logic [7:0]  a_out_byte;
    logic [15:0] a_count;
    logic        b_in_ready, b_out_valid, b_out_last, b_busy;
    logic [7:0]  b_out_byte;
    logic [15:0] b_count;
    logic        c_in_ready, c_out_valid, c_out_last, c_busy;
    logic [7:0]  c_out_byte;
    logic [3:0]  c_count;

    word_byte_serializer u_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(a_in_ready), .out_byte(a_out_byte), .out_valid(a_out_valid),
        .out_last(a_out_last), .out_ready(out_ready), .byte_count(a_count), .busy(a_busy)
    );

    word_byte_serializer #(.MSB_FIRST(1'b0)) u_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(b_in_ready), .out_byte(b_out_byte), .out_valid(b_out_valid),
        .out_last(b_out_last), .out_ready(out_ready), .byte_count(b_count), .busy(b_busy)
    );

    word_byte_serializer #(.CNT_W(4)) u_c (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(c_in_ready), .out_byte(c_out_byte), .out_valid(c_out_valid),
        .out_last(c_out_last), .out_ready(out_ready), .byte_count(c_count), .busy(c_busy)
    );

    int          sel = 0;
    logic        o_in_ready, o_valid, o_last, o_busy;
    logic [7:0]  o_byte;
    logic [15:0] o_count;

    always_comb begin
        o_in_ready = a_in_ready;
        o_valid    = a_out_valid;
        o_last     = a_out_last;
        o_busy     = a_busy;
        o_byte     = a_out_byte;
        o_count    = a_count;
        if (sel == 1) begin
            o_in_ready = b_in_ready;
            o_valid    = b_out_valid;
            o_last     = b_out_last;
            o_busy     = b_busy;
            o_byte     = b_out_byte;
            o_count    = b_count;
        end else if (sel == 2) begin
            o_in_ready = c_in_ready;
            o_valid    = c_out_valid;
            o_last     = c_out_last;
            o_busy     = c_busy;
            o_byte     = c_out_byte;
            o_count    = {12'h000, c_count};
        end
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_b[$];
    bit          exp_l[$];
    logic [31:0] push_w[$];
    bit          push_l[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_word(input logic [31:0] w, input bit last, input bit msb);
        for (int i = 0; i < 4; i++) begin
            exp_b.push_back(msb ? w[31-8*i -: 8] : w[8*i +: 8]);
            exp_l.push_back(last && (i == 3));
        end
        push_w.push_back(w);
        push_l.push_back(last);
    endtask

    task automatic do_reset;
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
        exp_b.delete(); exp_l.delete(); push_w.delete(); push_l.delete();
        #1;
        chk("rst_in_ready_low", o_in_ready, 0);
        @(posedge clk); #1;
        chk("rst_out_valid", o_valid, 0);
        chk("rst_out_byte", o_byte, 0);
        chk("rst_out_last", o_last, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_count", o_count, 0);
        rst = 1'b0; #1;
        chk("rst_in_ready_high", o_in_ready, 1);
    endtask

    task automatic push_all(input int budget);
        int k = 0;
        int cyc = 0;
        while (k < push_w.size() && cyc < budget) begin
            in_valid = 1'b1; in_data = push_w[k]; in_last = push_l[k];
            if (o_in_ready) k++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; in_last = 1'b0;
        chk("push_accepted", k, push_w.size());
    endtask

    task automatic drain(input int nbytes, input bit toggle, input bit strict, input int budget);
        int         got = 0;
        int         cyc = 0;
        int         gaps = 0;
        bit         phase = 1'b1;
        bit         held_v = 1'b0;
        logic [7:0] held = '0;
        while (got < nbytes && cyc < budget) begin
            out_ready = toggle ? phase : 1'b1;
            if (held_v) chk($sformatf("hold_byte%0d", got), o_byte, held);
            held_v = 1'b0;
            if (o_valid && out_ready) begin
                chk($sformatf("byte%0d", got), o_byte, exp_b.pop_front());
                chk($sformatf("last%0d", got), o_last, exp_l.pop_front());
                got++;
            end else if (o_valid) begin
                held = o_byte; held_v = 1'b1;
            end else if (strict && got > 0) begin
                gaps++;
            end
            @(posedge clk); #1;
            cyc++; phase = !phase;
        end
        out_ready = 1'b0;
        chk("drain_count", got, nbytes);
        if (strict) chk("drain_gaps", gaps, 0);
    endtask

    logic [31:0] t3_words [7];
    int          acc;
    int          seen;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Test 1: four words, out_ready high, bytes on consecutive cycles.
        sel = 0;
        do_reset();
        push_w = '{32'h01234567, 32'h89abcdef, 32'h23456789, 32'habcdef01};
        push_l = '{0, 0, 0, 0};
        exp_b = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hab, 8'hcd, 8'hef,
                  8'h23, 8'h45, 8'h67, 8'h89, 8'hab, 8'hcd, 8'hef, 8'h01};
        for (int i = 0; i < 16; i++) exp_l.push_back(1'b0);
        fork
            push_all(20);
            drain(16, 1'b0, 1'b1, 60);
        join
        @(posedge clk); #1;
        chk("t1_count", o_count, 16);
        chk("t1_busy", o_busy, 0);
        chk("t1_valid_idle", o_valid, 0);

        // Test 2: out_ready toggling, final word tagged last.
        do_reset();
        add_word(32'h01234567, 0, 1);
        add_word(32'h89abcdef, 0, 1);
        add_word(32'h23456789, 0, 1);
        add_word(32'habcdef01, 1, 1);
        fork
            push_all(20);
            drain(16, 1'b1, 1'b0, 80);
        join
        chk("t2_count", o_count, 16);

        // Test 3: stalled output, FIFO fills after 5 words.
        do_reset();
        t3_words = '{32'h11223344, 32'h55667788, 32'h99aabbcc, 32'hddeeff00,
                     32'h0f1e2d3c, 32'hdeadbeef, 32'hcafef00d};
        acc = 0;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            in_valid = 1'b1;
            in_data  = t3_words[(acc < 6) ? acc : 6];
            if (o_in_ready) acc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("t3_accepted", acc, 5);
        chk("t3_in_ready_full", o_in_ready, 0);
        chk("t3_valid_stalled", o_valid, 1);
        chk("t3_head_byte", o_byte, 8'h11);
        for (int i = 0; i < 5; i++) add_word(t3_words[i], 0, 1);
        drain(20, 1'b0, 1'b0, 60);
        repeat (3) @(posedge clk);
        #1;
        chk("t3_valid_after", o_valid, 0);
        chk("t3_count", o_count, 20);

        // Test 4: reset mid-word discards the remainder.
        do_reset();
        push_w = '{32'h01234567};
        push_l = '{0};
        exp_b = '{8'h01, 8'h23};
        exp_l = '{0, 0};
        push_all(5);
        drain(2, 1'b0, 1'b0, 10);
        rst = 1'b1; #1;
        chk("t4_in_ready_rst", o_in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0; #1;
        chk("t4_valid", o_valid, 0);
        chk("t4_count", o_count, 0);
        chk("t4_busy", o_busy, 0);
        chk("t4_in_ready", o_in_ready, 1);
        seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (o_valid) seen++;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        chk("t4_no_stale_bytes", seen, 0);
        exp_b.delete(); exp_l.delete(); push_w.delete(); push_l.delete();
        add_word(32'h89abcdef, 1, 1);
        fork
            push_all(5);
            drain(4, 1'b0, 1'b1, 20);
        join
        chk("t4_count_after", o_count, 4);

        // Test 5: LSB-first instance.
        sel = 1;
        do_reset();
        push_w = '{32'h01234567};
        push_l = '{0};
        exp_b = '{8'h67, 8'h45, 8'h23, 8'h01};
        exp_l = '{0, 0, 0, 0};
        fork
            push_all(5);
            drain(4, 1'b0, 1'b1, 20);
        join

        // Test 6: 4-bit counter wraps after 20 bytes.
        sel = 2;
        do_reset();
        add_word(32'h10203040, 0, 1);
        add_word(32'h50607080, 0, 1);
        add_word(32'h90a0b0c0, 0, 1);
        add_word(32'hd0e0f001, 0, 1);
        add_word(32'h02030405, 1, 1);
        fork
            push_all(30);
            drain(20, 1'b0, 1'b1, 80);
        join
        chk("t6_wrapped_count", c_count, 4);
        chk("t6_wide_count", a_count, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
